uart_ram_loader: RTL and testbench

Serial program loader that receives a framed byte stream on a UART RX pin (8N1) and writes it as 16-bit words into the CPU data RAM through the RAM write port (`writeEnable`/`writeAddr`/`writeData`). It sits in the top level beside the CPU. The CPU reads the RAM; this block fills it. Its `busy` output is ORed into the CPU reset, so the CPU restarts from a clean state once a load completes.

---
 rtl/uart_ram_loader.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_ram_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: 8N1 UART receiver feeding a framed loader that writes
// 16-bit big-endian words into RAM. Frame: Header, len_hi, len_lo, then
// len words (hi byte, lo byte). busy covers the whole load.
module uart_ram_loader #(
   parameter int unsigned ClksPerBit = 100,
   parameter int unsigned AddrWidth  = 16,
   parameter logic [7:0]  Header     = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 ramWriteEnable,
   output logic [AddrWidth-1:0] ramWriteAddr,
   output logic [15:0]          ramWriteData,
   output logic                 busy,
   output logic                 done,
   output logic                 frameError
);

   localparam int unsigned CntW = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] FullCnt = CntW'(ClksPerBit - 1);
   localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

   // Receiver states
   localparam logic [1:0] RxIdle  = 2'd0;
   localparam logic [1:0] RxStart = 2'd1;
   localparam logic [1:0] RxData  = 2'd2;
   localparam logic [1:0] RxStop  = 2'd3;

   // Loader states
   localparam logic [2:0] LdWaitHdr = 3'd0;
   localparam logic [2:0] LdLenHi   = 3'd1;
   localparam logic [2:0] LdLenLo   = 3'd2;
   localparam logic [2:0] LdDataHi  = 3'd3;
   localparam logic [2:0] LdDataLo  = 3'd4;

   // Synchronizer and edge history
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;

   // Receiver registers
   logic [1:0]      rx_state_q, rx_state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_byte_q, rx_byte_d;
   logic            byte_valid_q, byte_valid_d;
   logic            byte_err_q, byte_err_d;

   // Loader registers
   logic [2:0]           ld_state_q, ld_state_d;
   logic [15:0]          count_q, count_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [7:0]           hi_q, hi_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 we_q, we_d;
   logic [AddrWidth-1:0] waddr_q, waddr_d;
   logic [15:0]          wdata_q, wdata_d;

   logic [15:0] len_word;

   // Two-flop synchronizer; idle-high reset value avoids a false start edge
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Receiver next-state: start detect, mid-bit sampling, stop check
   always_comb begin
      rx_state_d   = rx_state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      byte_err_d   = 1'b0;
      case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RxStart;
               cnt_d      = '0;
            end
         end
         RxStart: begin
            if (cnt_q == HalfCnt) begin
               cnt_d      = '0;
               bit_d      = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RxData: begin
            if (cnt_q == FullCnt) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  rx_state_d = RxStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         RxStop: begin
            if (cnt_q == FullCnt) begin
               cnt_d      = '0;
               rx_state_d = RxIdle;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  rx_byte_d    = shift_q;
               end else begin
                  byte_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   // Receiver state register
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q   <= RxIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         byte_err_q   <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         byte_err_q   <= byte_err_d;
      end
   end

   assign len_word = {count_q[15:8], rx_byte_q};

   // Loader next-state: frame parsing, word assembly and write strobes
   always_comb begin
      ld_state_d = ld_state_q;
      count_d    = count_q;
      addr_d     = addr_q;
      hi_d       = hi_q;
      busy_d     = busy_q;
      err_d      = err_q;
      done_d     = 1'b0;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      if (byte_err_q) begin
         // A corrupted byte aborts an active load; partial words are dropped
         if (ld_state_q != LdWaitHdr) begin
            err_d      = 1'b1;
            busy_d     = 1'b0;
            ld_state_d = LdWaitHdr;
         end
      end else if (byte_valid_q) begin
         case (ld_state_q)
            LdWaitHdr: begin
               if (rx_byte_q == Header) begin
                  busy_d     = 1'b1;
                  err_d      = 1'b0;
                  addr_d     = '0;
                  ld_state_d = LdLenHi;
               end
            end
            LdLenHi: begin
               count_d    = {rx_byte_q, 8'h00};
               ld_state_d = LdLenLo;
            end
            LdLenLo: begin
               count_d = len_word;
               if (len_word == 16'd0) begin
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  ld_state_d = LdWaitHdr;
               end else begin
                  ld_state_d = LdDataHi;
               end
            end
            LdDataHi: begin
               hi_d       = rx_byte_q;
               ld_state_d = LdDataLo;
            end
            LdDataLo: begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdata_d = {hi_q, rx_byte_q};
               addr_d  = addr_q + AddrWidth'(1);
               count_d = count_q - 16'd1;
               if (count_q == 16'd1) begin
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  ld_state_d = LdWaitHdr;
               end else begin
                  ld_state_d = LdDataHi;
               end
            end
            default: ld_state_d = LdWaitHdr;
         endcase
      end
   end

   // Loader state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_state_q <= LdWaitHdr;
         count_q    <= '0;
         addr_q     <= '0;
         hi_q       <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
      end else begin
         ld_state_q <= ld_state_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         hi_q       <= hi_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         done_q     <= done_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign ramWriteEnable = we_q;
   assign ramWriteAddr   = waddr_q;
   assign ramWriteData   = wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign frameError     = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Scoreboard bench for uart_ram_loader: frames are parsed by a reference
// model into expected write/done events; a monitor pops and compares them.
module tb_uart_ram_loader;

   localparam int unsigned CPB = 8;
   localparam int unsigned AW  = 3;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [15:0]   data;
      logic          done;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic          ramWriteEnable;
   logic [AW-1:0] ramWriteAddr;
   logic [15:0]   ramWriteData;
   logic          busy;
   logic          done;
   logic          frameError;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   uart_ram_loader #(.ClksPerBit(CPB), .AddrWidth(AW), .Header(8'hA5)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx             (rx),
      .ramWriteEnable (ramWriteEnable),
      .ramWriteAddr   (ramWriteAddr),
      .ramWriteData   (ramWriteData),
      .busy           (busy),
      .done           (done),
      .frameError     (frameError)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Serialize one 8N1 byte, LSB first, then idle for gap bit times
   task automatic tx_byte(input logic [7:0] b, input logic stop_bit, input int gap);
      rx = 1'b0;
      cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cycles(CPB);
      end
      rx = stop_bit;
      cycles(CPB);
      rx = 1'b1;
      cycles(gap * CPB);
   endtask

   task automatic send_bytes(input byte_q_t bytes, input int gap);
      foreach (bytes[i]) tx_byte(bytes[i], 1'b1, gap);
   endtask

   // Reference: find the header, read the big-endian count, emit one event per word
   task automatic model_frame(input byte_q_t bytes);
      int   i;
      int   len;
      ev_t  e;
      i = 0;
      while (i < bytes.size() && bytes[i] != 8'hA5) i++;
      i++;
      len = int'(bytes[i]) * 256 + int'(bytes[i+1]);
      i += 2;
      if (len == 0) begin
         e = '{we: 1'b0, addr: '0, data: '0, done: 1'b1};
         exp_q.push_back(e);
      end
      for (int w = 0; w < len; w++) begin
         e.we   = 1'b1;
         e.addr = AW'(w % (1 << AW));
         e.data = {bytes[i + 2*w], bytes[i + 2*w + 1]};
         e.done = (w == len - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic load_frame(input byte_q_t bytes, input int gap);
      model_frame(bytes);
      send_bytes(bytes, gap);
   endtask

   task automatic push_write(input logic [AW-1:0] a, input logic [15:0] d, input logic dn);
      ev_t e;
      e = '{we: 1'b1, addr: a, data: d, done: dn};
      exp_q.push_back(e);
   endtask

   task automatic push_done_only();
      ev_t e;
      e = '{we: 1'b0, addr: '0, data: '0, done: 1'b1};
      exp_q.push_back(e);
   endtask

   initial begin
      int     busy_seen;
      byte_q_t fr;
      ev_t    e;

      // Monitor: every write strobe or done pulse must match the next expected event
      fork
         forever begin
            @(negedge clk);
            if (!rst && (ramWriteEnable || done)) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_event we=%0b addr=%0h data=%0h done=%0b exp=none",
                           ramWriteEnable, ramWriteAddr, ramWriteData, done);
               end else begin
                  e = exp_q.pop_front();
                  if (ramWriteEnable !== e.we || done !== e.done ||
                      (e.we && (ramWriteAddr !== e.addr || ramWriteData !== e.data))) begin
                     failures++;
                     $display("FAIL event got we=%0b addr=%0h data=%0h done=%0b exp we=%0b addr=%0h data=%0h done=%0b",
                              ramWriteEnable, ramWriteAddr, ramWriteData, done,
                              e.we, e.addr, e.data, e.done);
                  end
               end
            end
         end
      join_none

      // Reset state
      rst = 1'b1;
      rx  = 1'b1;
      cycles(2);
      check("reset_outputs", 32'({ramWriteEnable, ramWriteAddr, ramWriteData, busy, done, frameError}), 32'd0);
      rst = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      check("idle_busy", 32'(busy_seen), 32'd0);

      // Two-word load
      load_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1);
      cycles(2 * CPB);
      check("two_word_busy", 32'(busy), 32'd0);
      check("two_word_drain", 32'(exp_q.size()), 32'd0);

      // Leading garbage ignored, back-to-back bytes
      load_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF}, 0);
      cycles(2 * CPB);
      check("garbage_drain", 32'(exp_q.size()), 32'd0);

      // Zero-length load: busy only between header and LEN_LO
      push_done_only();
      tx_byte(8'hA5, 1'b1, 1);
      check("len0_busy_hdr", 32'(busy), 32'd1);
      tx_byte(8'h00, 1'b1, 1);
      check("len0_busy_lenhi", 32'(busy), 32'd1);
      tx_byte(8'h00, 1'b1, 1);
      check("len0_busy_end", 32'(busy), 32'd0);
      check("len0_drain", 32'(exp_q.size()), 32'd0);

      // Bad stop bit mid-load
      push_write('0, 16'h1122, 1'b0);
      send_bytes('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33}, 1);
      tx_byte(8'h44, 1'b0, 2);
      check("ferr_set", 32'(frameError), 32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      check("ferr_drain", 32'(exp_q.size()), 32'd0);
      tx_byte(8'hA5, 1'b1, 1);
      check("ferr_clear", 32'(frameError), 32'd0);
      check("ferr_rehdr_busy", 32'(busy), 32'd1);
      push_done_only();
      send_bytes('{8'h00, 8'h00}, 1);

      // Short glitch while idle and inside a load is not a byte
      rx = 1'b0;
      cycles(3);
      rx = 1'b1;
      cycles(4 * CPB);
      check("glitch_idle_busy", 32'(busy), 32'd0);
      fr = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
      model_frame(fr);
      send_bytes('{8'hA5, 8'h00, 8'h01}, 1);
      rx = 1'b0;
      cycles(3);
      rx = 1'b1;
      cycles(4 * CPB);
      check("glitch_load_busy", 32'(busy), 32'd1);
      send_bytes('{8'hBE, 8'hEF}, 1);
      cycles(CPB);
      check("glitch_drain", 32'(exp_q.size()), 32'd0);

      // Reset during a data byte
      push_write(3'd0, 16'h1122, 1'b0);
      push_write(3'd1, 16'h3344, 1'b0);
      send_bytes('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44}, 1);
      fork
         tx_byte(8'hFF, 1'b1, 3);
         begin
            cycles(30);
            rst = 1'b1;
            cycles(2);
            rst = 1'b0;
            @(negedge clk);
            check("rst_mid_busy", 32'(busy), 32'd0);
            check("rst_mid_ferr", 32'(frameError), 32'd0);
         end
      join
      load_frame('{8'hA5, 8'h00, 8'h01, 8'hCA, 8'hFE}, 1);

      // Address wrap past all-ones
      fr = '{8'hA5, 8'h00, 8'h0A};
      for (int w = 0; w < 20; w++) fr.push_back(8'($urandom_range(0, 255)));
      load_frame(fr, 0);

      // Randomized frames: garbage prefix, random length, random gaps
      for (int f = 0; f < 8; f++) begin
         int len;
         int ng;
         logic [7:0] g;
         fr = {};
         ng = int'($urandom_range(0, 2));
         for (int k = 0; k < ng; k++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h5A;
            fr.push_back(g);
         end
         len = int'($urandom_range(0, 11));
         fr.push_back(8'hA5);
         fr.push_back(8'(len >> 8));
         fr.push_back(8'(len));
         for (int k = 0; k < 2 * len; k++) fr.push_back(8'($urandom_range(0, 255)));
         load_frame(fr, int'($urandom_range(0, 2)));
         cycles(2 * CPB);
         check("rand_busy", 32'(busy), 32'd0);
      end

      cycles(200);
      check("final_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
